// File: rtl/uart_ram_ctrl_pkg.sv
// Shared definitions for the serial RAM frame controller: frame constants,
// controller state encoding, transmit handshake phases, counter sizing helper.
package uart_ram_ctrl_pkg;

  localparam logic [7:0] HDR    = 8'hA5;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_SEND,
    ST_SUM_SEND,
    ST_RESP,
    ST_ERR
  } state_e;

  // Handshake with the byte transmitter: request, see busy rise, see busy fall.
  typedef enum logic [1:0] {
    SND_START,
    SND_RISE,
    SND_FALL
  } snd_e;

  // Idle counter only has to hold values up to t-1.
  function automatic int unsigned tmo_width(input int unsigned t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/uart_ram_ctrl_byte_strobe.sv
// uart_byte_strobe: turns the receiver busy flag into a registered byte
// strobe and watches for inter-byte silence inside a frame.
//   rx_data/rx_int : receiver byte and busy flag
//   tmo_en         : idle counting enabled (controller is mid-frame)
//   rx_vld/rx_byte : one-cycle strobe with the captured byte
//   rx_tmo         : idle count reached TIMEOUT with no strobe this cycle
module uart_byte_strobe
  import uart_ram_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_int,
  input  logic       tmo_en,
  output logic       rx_vld,
  output logic [7:0] rx_byte,
  output logic       rx_tmo
);

  localparam int unsigned CW = tmo_width(TIMEOUT);

  logic          rx_int_q;
  logic          vld_q;
  logic [7:0]    byte_q;
  logic [CW-1:0] idle_q, idle_d;
  logic          fall;

  assign fall    = rx_int_q & ~rx_int;
  assign rx_vld  = vld_q;
  assign rx_byte = byte_q;
  // A strobe in the terminal cycle wins over the timeout.
  assign rx_tmo  = tmo_en & ~vld_q & (idle_q == CW'(TIMEOUT - 1));

  always_comb begin
    idle_d = idle_q + 1'b1;
    if (!tmo_en || vld_q || rx_tmo) idle_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_int_q <= 1'b0;
      vld_q    <= 1'b0;
      byte_q   <= '0;
      idle_q   <= '0;
    end else begin
      rx_int_q <= rx_int;
      vld_q    <= fall;
      if (fall) byte_q <= rx_data;
      idle_q   <= idle_d;
    end
  end

endmodule

// File: rtl/uart_ram_ctrl.sv
// uart_ram_ctrl: parses A5/CMD/ADDR/LEN/DATA/CHK frames from the byte
// receiver, writes or reads the byte RAM and answers through the transmitter.
//   rx_data/rx_int       : receiver byte / busy flag
//   ram_addr/we/wdata    : RAM write port and read address
//   ram_rdata            : RAM read data, one cycle after ram_addr
//   tx_start/tx_data     : transmit request and byte
//   tx_busy              : transmitter busy
//   busy                 : controller not idle
//   frame_ok / frame_err : frame result pulses
module uart_ram_ctrl
  import uart_ram_ctrl_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_int,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic          busy,
  output logic          frame_ok,
  output logic          frame_err
);

  state_e        state_q, state_d;
  snd_e          snd_q, snd_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    len_q, len_d, cnt_q, cnt_d;
  logic [7:0]    acc_q, acc_d, sum_q, sum_d, resp_q, resp_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;

  logic       rx_vld, rx_tmo, tmo_en;
  logic [7:0] rx_byte;
  logic [7:0] snd_byte;

  assign tmo_en = state_q inside {ST_CMD, ST_ADDR, ST_LEN, ST_DATA, ST_CHK};

  uart_byte_strobe #(.TIMEOUT(TIMEOUT)) u_strobe (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_int  (rx_int),
    .tmo_en  (tmo_en),
    .rx_vld  (rx_vld),
    .rx_byte (rx_byte),
    .rx_tmo  (rx_tmo)
  );

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign snd_byte  = (state_q == ST_RESP) ? resp_q : sum_q;

  always_comb begin
    state_d     = state_q;
    snd_d       = snd_q;
    rd_d        = rd_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    resp_d      = resp_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_vld && rx_byte == HDR) begin
          state_d = ST_CMD;
          acc_d   = '0;
        end
      end
      ST_CMD, ST_ADDR, ST_LEN, ST_DATA, ST_CHK: begin
        if (rx_vld) begin
          acc_d = acc_q ^ rx_byte;
          unique case (state_q)
            ST_CMD: begin
              if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
                rd_d    = (rx_byte == CMD_RD);
                state_d = ST_ADDR;
              end else begin
                state_d = ST_ERR;
              end
            end
            ST_ADDR: begin
              ptr_d   = AW'(rx_byte);
              state_d = ST_LEN;
            end
            ST_LEN: begin
              len_d = rx_byte;
              cnt_d = '0;
              if (rx_byte == 8'd0) state_d = ST_ERR;
              else if (rd_q)       state_d = ST_CHK;
              else                 state_d = ST_DATA;
            end
            ST_DATA: begin
              ram_we_d    = 1'b1;
              ram_addr_d  = ptr_q;
              ram_wdata_d = rx_byte;
              ptr_d       = ptr_q + 1'b1;
              cnt_d       = cnt_q + 8'd1;
              if (cnt_q + 8'd1 == len_q) state_d = ST_CHK;
            end
            default: begin
              // Writes have already advanced ptr_q; a read still has ADDR there.
              if (rx_byte == acc_q) begin
                if (rd_q) begin
                  state_d    = ST_RD_REQ;
                  ram_addr_d = ptr_q;
                  cnt_d      = '0;
                  sum_d      = '0;
                end else begin
                  state_d    = ST_RESP;
                  resp_d     = ACK;
                  snd_d      = SND_START;
                  frame_ok_d = 1'b1;
                end
              end else begin
                state_d     = ST_RESP;
                resp_d      = NAK;
                snd_d       = SND_START;
                frame_err_d = 1'b1;
              end
            end
          endcase
        end else if (rx_tmo) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        tx_data_d  = ram_rdata;
        tx_start_d = 1'b1;
        sum_d      = sum_q ^ ram_rdata;
        snd_d      = SND_RISE;
        state_d    = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (snd_q == SND_RISE) begin
          if (tx_busy) snd_d = SND_FALL;
        end else if (!tx_busy) begin
          if (cnt_q + 8'd1 == len_q) begin
            state_d    = ST_SUM_SEND;
            snd_d      = SND_START;
            frame_ok_d = 1'b1;
          end else begin
            state_d    = ST_RD_REQ;
            cnt_d      = cnt_q + 8'd1;
            ptr_d      = ptr_q + 1'b1;
            ram_addr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_RESP, ST_SUM_SEND: begin
        unique case (snd_q)
          SND_START: begin
            if (!tx_busy) begin
              tx_start_d = 1'b1;
              tx_data_d  = snd_byte;
              snd_d      = SND_RISE;
            end
          end
          SND_RISE: if (tx_busy) snd_d = SND_FALL;
          default:  if (!tx_busy) state_d = ST_IDLE;
        endcase
      end
      ST_ERR: begin
        frame_err_d = 1'b1;
        resp_d      = NAK;
        snd_d       = SND_START;
        state_d     = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      snd_q       <= SND_START;
      rd_q        <= 1'b0;
      ptr_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      resp_q      <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snd_q       <= snd_d;
      rd_q        <= rd_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      resp_q      <= resp_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_ram_ctrl.sv
// Bench for uart_ram_ctrl: byte RAM and transmitter environment, a frame-level
// reference model, one per-cycle compare process and literal spot checks.
module tb_uart_ram_ctrl;

  localparam int unsigned TMO   = 300;
  localparam int unsigned TXLEN = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_int = 1'b0;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       busy, frame_ok, frame_err;

  always #5 clk = ~clk;

  uart_ram_ctrl #(.AW(8), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  // Environment: synchronous byte RAM and a transmitter that is busy TXLEN cycles.
  logic [7:0] ram [256];
  int         tx_cnt = 0;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
    if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_busy <= 1'b0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      tx_cnt  <= TXLEN;
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0]  model_mem [256];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  txlog[$];
  logic [7:0]  frm[$];
  int          exp_ok = 0, exp_err = 0, seen_ok = 0, seen_err = 0;

  task automatic model_frame();
    int unsigned i = 0;
    logic [7:0] cmd, addr, len, acc, d, sum, a;
    while (i < frm.size() && frm[i] != 8'hA5) i++;
    if (i >= frm.size()) return;
    i++;
    if (i >= frm.size()) begin exp_err++; return; end
    cmd = frm[i]; i++;
    if (cmd != 8'h01 && cmd != 8'h02) begin exp_err++; exp_tx.push_back(8'h15); return; end
    if (i >= frm.size()) begin exp_err++; return; end
    addr = frm[i]; i++;
    if (i >= frm.size()) begin exp_err++; return; end
    len = frm[i]; i++;
    if (len == 8'd0) begin exp_err++; exp_tx.push_back(8'h15); return; end
    acc = cmd ^ addr ^ len;
    if (cmd == 8'h01) begin
      for (int unsigned k = 0; k < len; k++) begin
        if (i >= frm.size()) begin exp_err++; return; end
        d = frm[i]; i++;
        a = addr + 8'(k);
        model_mem[a] = d;
        exp_wr.push_back({a, d});
        acc ^= d;
      end
    end
    if (i >= frm.size()) begin exp_err++; return; end
    if (frm[i] != acc) begin exp_err++; exp_tx.push_back(8'h15); return; end
    exp_ok++;
    if (cmd == 8'h01) exp_tx.push_back(8'h06);
    else begin
      sum = '0;
      for (int unsigned k = 0; k < len; k++) begin
        a = addr + 8'(k);
        exp_tx.push_back(model_mem[a]);
        sum ^= model_mem[a];
      end
      exp_tx.push_back(sum);
    end
  endtask

  // Compare process: every RAM write and every transmit request.
  logic [15:0] wexp;
  logic [7:0]  texp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL ram_write unexpected addr=%h data=%h", ram_addr, ram_wdata);
        end else begin
          wexp = exp_wr.pop_front();
          if ({ram_addr, ram_wdata} !== wexp) begin
            failures++;
            $display("FAIL ram_write got addr=%h data=%h want addr=%h data=%h",
                     ram_addr, ram_wdata, wexp[15:8], wexp[7:0]);
          end
        end
      end
      if (tx_start) begin
        txlog.push_back(tx_data);
        checks++;
        if (tx_busy) begin
          failures++;
          $display("FAIL tx_start_while_busy got tx_busy=1 want 0");
        end
        checks++;
        if (exp_tx.size() == 0) begin
          failures++;
          $display("FAIL tx_byte unexpected got %h", tx_data);
        end else begin
          texp = exp_tx.pop_front();
          if (tx_data !== texp) begin
            failures++;
            $display("FAIL tx_byte got %h want %h", tx_data, texp);
          end
        end
      end
      if (frame_ok) seen_ok++;
      if (frame_err) seen_err++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_int  = 1'b1;
    repeat (3) @(negedge clk);
    rx_int = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle();
    repeat (3) @(negedge clk);
    for (int c = 0; c < 5000 && busy; c++) @(negedge clk);
    chk("idle_reached", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_end();
    chk("writes_pending", exp_wr.size(), 0);
    chk("tx_pending", exp_tx.size(), 0);
    chk("frame_ok_count", seen_ok, exp_ok);
    chk("frame_err_count", seen_err, exp_err);
  endtask

  task automatic run_frame(input bit silent);
    txlog.delete();
    model_frame();
    foreach (frm[k]) send_byte(frm[k]);
    if (silent) begin
      repeat (TMO + 10) @(negedge clk);
      chk("busy_after_timeout", 32'(busy), 32'd0);
    end else begin
      wait_idle();
    end
    check_end();
  endtask

  task automatic chk_tx(input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] w [4];
    w = '{b0, b1, b2, b3};
    chk("tx_count", txlog.size(), n);
    if (txlog.size() == n)
      for (int k = 0; k < n; k++) chk("tx_literal", txlog[k], w[k]);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {ram_addr, ram_we, ram_wdata, tx_start, tx_data, busy, frame_ok, frame_err}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 256; k++) begin
      ram[k] = '0;
      model_mem[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good write (XOR of 01 10 03 11 22 33 is 0x12).
    frm = {8'hA5, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h12};
    run_frame(1'b0);
    chk("ram_10", ram[8'h10], 8'h11);
    chk("ram_11", ram[8'h11], 8'h22);
    chk("ram_12", ram[8'h12], 8'h33);
    chk_tx(1, 8'h06, 8'h00, 8'h00, 8'h00);
    chk("ok_after_write", seen_ok, 1);

    // Read back.
    frm = {8'hA5, 8'h02, 8'h10, 8'h03, 8'h11};
    run_frame(1'b0);
    chk_tx(4, 8'h11, 8'h22, 8'h33, 8'h00);

    // Bad checksum: write stays committed.
    frm = {8'hA5, 8'h01, 8'h20, 8'h01, 8'hAA, 8'h00};
    run_frame(1'b0);
    chk("ram_20", ram[8'h20], 8'hAA);
    chk_tx(1, 8'h15, 8'h00, 8'h00, 8'h00);
    chk("err_after_badchk", seen_err, 1);

    // Address wrap on write and read.
    frm = {8'hA5, 8'h01, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFF};
    run_frame(1'b0);
    chk("ram_ff", ram[8'hFF], 8'h01);
    chk("ram_00", ram[8'h00], 8'h02);
    frm = {8'hA5, 8'h02, 8'hFF, 8'h02, 8'hFF};
    run_frame(1'b0);
    chk_tx(3, 8'h01, 8'h02, 8'h03, 8'h00);

    // LEN=0 and unknown command.
    frm = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h77};
    run_frame(1'b0);
    chk_tx(1, 8'h15, 8'h00, 8'h00, 8'h00);
    frm = {8'hA5, 8'h07};
    run_frame(1'b0);
    chk_tx(1, 8'h15, 8'h00, 8'h00, 8'h00);

    // Garbage then a stalled frame.
    frm = {8'h3C, 8'hA5, 8'h01};
    run_frame(1'b1);
    chk_tx(0, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset while the first read byte is on the wire.
    txlog.delete();
    exp_tx.push_back(8'h11);
    frm = {8'hA5, 8'h02, 8'h10, 8'h03, 8'h11};
    foreach (frm[k]) send_byte(frm[k]);
    for (int c = 0; c < 2000 && exp_tx.size() != 0; c++) @(negedge clk);
    chk("first_read_byte_sent", exp_tx.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midread_reset_outputs");
    repeat (3) @(negedge clk);
    chk_outputs_zero("midread_reset_hold");
    rst_n = 1'b1;
    repeat (TXLEN + 4) @(negedge clk);
    check_end();

    frm = {8'hA5, 8'h02, 8'h10, 8'h03, 8'h11};
    run_frame(1'b0);
    chk_tx(4, 8'h11, 8'h22, 8'h33, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
